// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath: sequences fetch, decode,
// execute, memory and writeback over one shared ALU and one memory port.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memread,
    output logic        memwrite,
    output logic        iord,
    output logic        irwrite,
    output logic        mdrwrite,
    output logic        pcwrite,
    output logic        pcsrc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic        reg2loc,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        instr_done,
    output logic        error,
    output logic [3:0]  state
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ERR      = 4'd15
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              mem_state;
    logic              timeout;
    logic              is_cbz;

    always_comb begin
        is_cbz    = (op[10:3] == OP_CBZ);
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        timeout   = mem_state && !mem_ready && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_LDUR || op == OP_STUR)
                    state_d = S_MEMADR;
                else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
                    state_d = S_EXEC_R;
                else if (is_cbz)
                    state_d = S_BRANCH;
                else
                    state_d = S_ERR;
            end
            S_MEMADR:   state_d = (op == OP_LDUR) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ERR:      state_d = S_ERR;
            default:    state_d = S_ERR;
        endcase
        if (timeout) state_d = S_ERR;

        // Counter restarts on every state change and saturates rather than wrapping.
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_state && !mem_ready && wait_cnt_q != CNT_W'(MEM_TIMEOUT))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        mdrwrite   = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        reg2loc    = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        instr_done = 1'b0;
        error      = 1'b0;
        state      = state_q;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                reg2loc = (op == OP_STUR) || is_cbz;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD: begin
                mem_req  = 1'b1;
                memread  = 1'b1;
                iord     = 1'b1;
                mdrwrite = mem_ready;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                memwrite   = 1'b1;
                iord       = 1'b1;
                reg2loc    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                reg2loc    = 1'b1;
                pcsrc      = 1'b1;
                pcwrite    = zero;
                instr_done = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues instructions with random
// memory stalls and queues per-instruction expectations; a monitor checks retirements.
module tb_multicycle_ctrl;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_ILL = 4, K_TMO = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] op = 11'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, memread, memwrite, iord, irwrite, mdrwrite, pcwrite, pcsrc;
    logic        alusrca, reg2loc, regwrite, memtoreg, instr_done, error;
    logic [1:0]  alusrcb, aluop;
    logic [3:0]  state;
    logic [16:0] outs;
    logic        rst_seen = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memread(memread), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .mdrwrite(mdrwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .reg2loc(reg2loc),
        .regwrite(regwrite), .memtoreg(memtoreg), .instr_done(instr_done),
        .error(error), .state(state)
    );

    assign outs = {mem_req, memread, memwrite, iord, irwrite, mdrwrite, pcwrite, pcsrc,
                   alusrca, alusrcb, aluop, reg2loc, regwrite, memtoreg, instr_done};

    always @(posedge clk) rst_seen <= !reset;

    typedef struct {
        int kind; int lat; int irw; int mdrw; int pcw; int regw; int m2r; int pcsrc;
        int a10; int a01; int r2l; int iord; int memrd; int b11; int b10;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic bit is_legal(input logic [10:0] o);
        logic [10:0] legal[6] = '{11'b11111000010, 11'b11111000000, 11'b10001011000,
                                  11'b11001011000, 11'b10001010000, 11'b10101010000};
        logic [7:0] cbz_pfx = 8'b10110100;
        foreach (legal[i]) if (o == legal[i]) return 1'b1;
        return (o[10:3] == cbz_pfx);
    endfunction

    function automatic logic [10:0] pick_op(input int kind);
        logic [10:0] rops[4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        logic [10:0] o;
        case (kind)
            K_R:   o = rops[$urandom_range(0, 3)];
            K_LD:  o = 11'b11111000010;
            K_ST:  o = 11'b11111000000;
            K_CBZ: o = {8'b10110100, 3'($urandom)};
            default: begin
                o = 11'($urandom);
                while (is_legal(o)) o = 11'($urandom);
            end
        endcase
        return o;
    endfunction

    // Expected per-instruction totals derived from the instruction class and stall counts.
    function automatic exp_t model(input int kind, input int wf, input int wm, input bit z);
        exp_t e;
        e = '{kind: kind, lat: 0, irw: 1, mdrw: 0, pcw: 1, regw: 0, m2r: 0, pcsrc: 0,
              a10: 0, a01: 0, r2l: 0, iord: 0, memrd: wf + 1, b11: 1, b10: 0};
        case (kind)
            K_R:   begin e.lat = wf + 4; e.regw = 1; e.a10 = 1; end
            K_LD:  begin e.lat = wf + wm + 5; e.mdrw = 1; e.regw = 1; e.m2r = 1;
                         e.iord = wm + 1; e.memrd = wf + wm + 2; e.b10 = 1; end
            K_ST:  begin e.lat = wf + wm + 4; e.r2l = wm + 2; e.iord = wm + 1; e.b10 = 1; end
            K_CBZ: begin e.lat = wf + 3; e.pcw = 1 + int'(z); e.pcsrc = 1; e.a01 = 1; e.r2l = 2; end
            K_ILL: e.lat = wf + 2;
            default: e.lat = 16;
        endcase
        return e;
    endfunction

    task automatic step(input bit rdy);
        mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        reset = 1'b0;
        mem_ready = rdy;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int kind, input logic [10:0] o, input int wf, input int wm, input bit z);
        sb.push_back(model(kind, wf, wm, z));
        op = o;
        zero = z;
        if (kind == K_TMO) begin
            repeat (16) step(1'b0);
        end else begin
            repeat (wf) step(1'b0);
            step(1'b1);
            step(1'($urandom));
            case (kind)
                K_R:   begin step(1'($urandom)); step(1'($urandom)); end
                K_LD:  begin step(1'($urandom)); repeat (wm) step(1'b0); step(1'b1); step(1'($urandom)); end
                K_ST:  begin step(1'($urandom)); repeat (wm) step(1'b0); step(1'b1); end
                K_CBZ: step(1'($urandom));
                default: ;
            endcase
        end
        if (kind >= K_ILL) begin
            repeat (3) step(1'b1);
            do_reset(1'b1);
        end
    endtask

    // Monitor: accumulates activity per instruction and checks on retire or trap.
    initial begin
        int cyc, irw, mdrw, pcw, a10, a01, r2l, io, mrd, b11, b10;
        bit in_err;
        exp_t e;
        {cyc, irw, mdrw, pcw, a10, a01, r2l, io, mrd, b11, b10} = '0;
        in_err = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_seen || state == 4'd0) begin
                chk("idle_state", int'(state), 0);
                chk("idle_outputs", int'(outs), 0);
                chk("idle_error", int'(error), 0);
                {cyc, irw, mdrw, pcw, a10, a01, r2l, io, mrd, b11, b10} = '0;
                in_err = 1'b0;
            end else if (state == 4'd15) begin
                if (!in_err) begin
                    in_err = 1'b1;
                    if (sb.size() == 0) chk("unexpected_trap", 0, 1);
                    else begin
                        e = sb.pop_front();
                        chk("trap_expected", int'(e.kind >= K_ILL), 1);
                        chk("trap_latency", cyc, e.lat);
                    end
                end
                chk("err_flag", int'(error), 1);
                chk("err_outputs", int'(outs), 0);
            end else begin
                cyc++;
                irw += int'(irwrite); mdrw += int'(mdrwrite); pcw += int'(pcwrite);
                a10 += int'(aluop == 2'b10); a01 += int'(aluop == 2'b01);
                r2l += int'(reg2loc); io += int'(iord); mrd += int'(memread);
                b11 += int'(alusrcb == 2'b11); b10 += int'(alusrcb == 2'b10);
                chk("error_low", int'(error), 0);
                if (instr_done) begin
                    if (sb.size() == 0) chk("unexpected_retire", 0, 1);
                    else begin
                        e = sb.pop_front();
                        chk("retire_not_trap", int'(e.kind < K_ILL), 1);
                        chk("latency", cyc, e.lat);
                        chk("irwrite_pulses", irw, e.irw);
                        chk("mdrwrite_pulses", mdrw, e.mdrw);
                        chk("pcwrite_pulses", pcw, e.pcw);
                        chk("regwrite_at_retire", int'(regwrite), e.regw);
                        chk("memtoreg_at_retire", int'(memtoreg), e.m2r);
                        chk("pcsrc_at_retire", int'(pcsrc), e.pcsrc);
                        chk("aluop_funct_cycles", a10, e.a10);
                        chk("aluop_passb_cycles", a01, e.a01);
                        chk("reg2loc_cycles", r2l, e.r2l);
                        chk("iord_cycles", io, e.iord);
                        chk("memread_cycles", mrd, e.memrd);
                        chk("alusrcb_imm2_cycles", b11, e.b11);
                        chk("alusrcb_imm_cycles", b10, e.b10);
                    end
                    {cyc, irw, mdrw, pcw, a10, a01, r2l, io, mrd, b11, b10} = '0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, pending=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, wf, wm;
        do_reset(1'b0);
        run_instr(K_R,   11'b10001011000, 0, 0, 1'b0);
        run_instr(K_LD,  pick_op(K_LD),   0, 3, 1'b0);
        run_instr(K_CBZ, pick_op(K_CBZ),  0, 0, 1'b1);
        run_instr(K_CBZ, pick_op(K_CBZ),  0, 0, 1'b0);
        run_instr(K_ST,  pick_op(K_ST),   0, 0, 1'b0);
        run_instr(K_R,   pick_op(K_R),   15, 0, 1'b0);
        run_instr(K_LD,  pick_op(K_LD),   2, 15, 1'b1);
        run_instr(K_TMO, pick_op(K_R),   16, 0, 1'b0);
        run_instr(K_ILL, 11'h000,         0, 0, 1'b0);
        // Reset during a stalled store: the access is abandoned without retiring.
        op = pick_op(K_ST);
        step(1'b1); step(1'($urandom)); step(1'($urandom)); step(1'b0);
        do_reset(1'b0);
        for (int n = 0; n < 40; n++) begin
            kind = ($urandom_range(0, 19) == 0) ? K_ILL : $urandom_range(K_R, K_CBZ);
            wf = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            run_instr(kind, pick_op(kind), wf, wm, 1'($urandom));
        end
        repeat (4) step(1'b1);
        // Leave the bench mid-fetch cleanly: any unretired expectation is a miss.
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
